// File: rtl/sync_fifo.sv
// Single-clock 8x16 FIFO with registered full/empty, look-ahead flags,
// occupancy counters and a show-ahead view of the head word.
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en0,
    input  logic                  rd_en0,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  full,
    output logic                  empty,
    output logic                  full_nxt,
    output logic                  empty_nxt,
    output logic [CNT_WIDTH-1:0]  room_avail,
    output logic [CNT_WIDTH-1:0]  data_avail,
    output logic [DATA_WIDTH-1:0] memory_wire
);

    localparam logic [CNT_WIDTH-1:0]  CNT_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wp;
    logic [ADDR_WIDTH-1:0] rp;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic                  wr_acc;
    logic                  rd_acc;

    // Enables are single-cycle requests; a request is taken only when the
    // registered flag allows it, otherwise it is dropped without side effects.
    always_comb begin
        wr_acc    = wr_en0 & ~full;
        rd_acc    = rd_en0 & ~empty;
        count_nxt = count + {{(CNT_WIDTH-1){1'b0}}, wr_acc}
                          - {{(CNT_WIDTH-1){1'b0}}, rd_acc};
        full_nxt  = (count_nxt == CNT_FULL);
        empty_nxt = (count_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            read_data <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
        end else begin
            if (wr_acc) begin
                mem[wp] <= write_data;
                wp      <= (wp == PTR_LAST) ? '0 : wp + 1'b1;
            end
            if (rd_acc) begin
                read_data <= mem[rp];
                rp        <= (rp == PTR_LAST) ? '0 : rp + 1'b1;
            end
            count <= count_nxt;
            full  <= full_nxt;
            empty <= empty_nxt;
        end
    end

    assign room_avail  = CNT_FULL - count;
    assign data_avail  = count;
    assign memory_wire = mem[rp];

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo: a reference queue predicts
// read_data, the head word, counters and flags for every step.
module tb_sync_fifo;

  logic        clk;
  logic        reset;
  logic        wr_en0;
  logic        rd_en0;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        full;
  logic        empty;
  logic        full_nxt;
  logic        empty_nxt;
  logic [3:0]  room_avail;
  logic [3:0]  data_avail;
  logic [15:0] memory_wire;

  sync_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en0      (wr_en0),
    .rd_en0      (rd_en0),
    .write_data  (write_data),
    .read_data   (read_data),
    .full        (full),
    .empty       (empty),
    .full_nxt    (full_nxt),
    .empty_nxt   (empty_nxt),
    .room_avail  (room_avail),
    .data_avail  (data_avail),
    .memory_wire (memory_wire)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [15:0] exp_q[$];
  logic [15:0] exp_rd;
  int          m_cnt;
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("full", {15'd0, full}, {15'd0, m_cnt == 8});
    chk("empty", {15'd0, empty}, {15'd0, m_cnt == 0});
    chk("data_avail", {12'd0, data_avail}, 16'(m_cnt));
    chk("room_avail", {12'd0, room_avail}, 16'(8 - m_cnt));
    chk("read_data", read_data, exp_rd);
    if (m_cnt > 0) chk("memory_wire", memory_wire, exp_q[0]);
  endtask

  // one clock of stimulus; look-ahead flags checked before the edge
  task automatic step(input logic w, input logic r, input logic [15:0] d);
    logic wa;
    logic ra;
    int   nc;
    wr_en0     = w;
    rd_en0     = r;
    write_data = d;
    #1;
    wa = w && (m_cnt < 8);
    ra = r && (m_cnt > 0);
    nc = m_cnt + int'(wa) - int'(ra);
    chk("full_nxt", {15'd0, full_nxt}, {15'd0, nc == 8});
    chk("empty_nxt", {15'd0, empty_nxt}, {15'd0, nc == 0});
    @(posedge clk);
    #1;
    if (ra) exp_rd = exp_q.pop_front();
    if (wa) exp_q.push_back(d);
    m_cnt  = nc;
    wr_en0 = 1'b0;
    rd_en0 = 1'b0;
    check_state();
  endtask

  // reset with enables active to show they are ignored
  task automatic do_reset();
    reset      = 1'b1;
    wr_en0     = 1'b1;
    rd_en0     = 1'b1;
    write_data = 16'(($urandom_range(1, 16'hffff)));
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    wr_en0 = 1'b0;
    rd_en0 = 1'b0;
    exp_q.delete();
    m_cnt  = 0;
    exp_rd = '0;
    check_state();
    chk("reset_memory_wire", memory_wire, 16'h0000);
    #1;
    chk("reset_full_nxt", {15'd0, full_nxt}, 16'h0000);
    chk("reset_empty_nxt", {15'd0, empty_nxt}, 16'h0001);
  endtask

  task automatic pair_loop(input int n);
    logic [15:0] v;
    for (int i = 0; i < n; i++) begin
      v = 16'($urandom_range(0, 16'hffff));
      step(1'b1, 1'b0, v);
      step(1'b0, 1'b0, 16'h0);
      step(1'b0, 1'b1, 16'h0);
      chk("pair_read", read_data, v);
      step(1'b0, 1'b0, 16'h0);
    end
  endtask

  initial begin
    logic [15:0] t;
    total      = 0;
    bad        = 0;
    m_cnt      = 0;
    exp_rd     = '0;
    reset      = 1'b1;
    wr_en0     = 1'b0;
    rd_en0     = 1'b0;
    write_data = '0;
    @(posedge clk);
    #1;

    do_reset();

    // single write/read pairs, pointers wrap after eight
    pair_loop(8);

    // fill and overflow
    for (int i = 1; i <= 9; i++) begin
      t = 16'(i);
      step(1'b1, 1'b0, ~t);
    end
    chk("fill_count", {12'd0, data_avail}, 16'd8);

    // drain and underflow
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'h0);
    chk("drain_last", read_data, 16'hfff7);

    // simultaneous at count 3
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'($urandom_range(0, 16'hffff)));
    step(1'b1, 1'b1, 16'h1234);
    chk("sim3_count", {12'd0, data_avail}, 16'd3);

    // simultaneous at full: write dropped
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'($urandom_range(0, 16'hffff)));
    step(1'b1, 1'b1, 16'hbeef);
    chk("simfull_count", {12'd0, data_avail}, 16'd7);

    // simultaneous at empty: read dropped
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 16'h0);
    t = read_data;
    step(1'b1, 1'b1, 16'hcafe);
    chk("simempty_hold", read_data, t);
    chk("simempty_count", {12'd0, data_avail}, 16'd1);

    // reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'($urandom_range(1, 16'hffff)));
    do_reset();
    pair_loop(4);

    if (exp_q.size() != 0) $display("note: %0d words still queued", exp_q.size());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, 8-entry × 16-bit first-in/first-out buffer with registered status flags, look-ahead flags and occupancy counters. It decouples a producer and a consumer running on the same clock. Writes and reads are single-cycle enable strobes. Overflowing writes and underflowing reads are silently dropped.

## Interface
Parameters:
- DATA_WIDTH, 16: word width.
- DEPTH, 8: number of entries.
- ADDR_WIDTH, 3: pointer width, log2(DEPTH).
- CNT_WIDTH, 4: counter width, able to hold 0..DEPTH.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on a rising edge while high.
- wr_en0  in  1  write request for this cycle.
- rd_en0  in  1  read request for this cycle.
- write_data  in  16  word to store when a write is accepted.
- read_data  out  16  registered word popped by the last accepted read.
- full  out  1  registered; high when the count is 8.
- empty  out  1  registered; high when the count is 0.
- full_nxt  out  1  combinational; value full will take after the next edge, given the current enables.
- empty_nxt  out  1  combinational; value empty will take after the next edge.
- room_avail  out  4  registered free slots, 8 − count.
- data_avail  out  4  registered stored words, equal to count.
- memory_wire  out  16  combinational; storage word at the current read pointer (head of queue, show-ahead).

## Operation
- State:
  - 8×16 storage array.
  - 3-bit write pointer wp.
  - 3-bit read pointer rp.
  - 4-bit count.
  - read_data register.
  - full and empty registers.
- Write accepted: wr_acc = wr_en0 & ~full.
  - mem[wp] <= write_data.
  - wp <= wp+1, wrapping 7→0.
- Read accepted: rd_acc = rd_en0 & ~empty.
  - read_data <= mem[rp].
  - rp <= rp+1, wrapping 7→0.
- Count update: count <= count + wr_acc − rd_acc.
  - room_avail = 8 − count.
  - data_avail = count.
  - room_avail + data_avail is always 8.
- Flag update:
  - full <= (next count == 8).
  - empty <= (next count == 0).
  - full_nxt and empty_nxt present those same next values combinationally.
- Acceptance is decided from the registered flags only:
  - When full, a write is dropped even if a read is accepted in the same cycle. Result: count goes 8→7 and the data is unchanged.
  - When empty, a read is dropped even with a simultaneous write. Result: count goes 0→1 and read_data holds.
- Rejected operations leave pointers, count, storage and read_data unchanged. No error output.
- read_data holds its value between accepted reads.
- Simultaneous accepted read and write:
  - Both pointers advance.
  - Count unchanged.
  - Flags unchanged.
- Reset (synchronous, high at a rising edge), regardless of other inputs:
  - wp = rp = 0, count = 0.
  - All storage words = 0.
  - read_data = 0.
  - empty = 1, full = 0.
  - room_avail = 8, data_avail = 0.
  - full_nxt = 0, empty_nxt = 1.
  - memory_wire = 0.
- Reset asserted mid-operation discards all contents. Enables sampled in the reset cycle are ignored.

## Timing
- Write latency: a word written at edge N is visible on memory_wire from N if the FIFO was empty, and is poppable by rd_en0 high at edge N+1 or later.
- Read latency: read_data updates at the same edge that samples rd_en0. It is valid one cycle after the request cycle.
- Flags and counters are registered and update at the edge that accepts the operation.
- full_nxt and empty_nxt settle within the cycle from wr_en0, rd_en0 and current state. They are not registered.
- memory_wire changes after any edge that moves rp or writes mem[rp].
- No combinational path from write_data to read_data.

## Test plan
- Reset: hold reset high 2 cycles → empty=1, full=0, data_avail=0, room_avail=8, read_data=0, memory_wire=0.
- Single write/read pairs: 8 iterations of write a random value, idle, read, idle → each read_data equals the value just written; data_avail toggles 0→1→0; pointers wrap after iteration 8.
- Fill and overflow: write ~1..~9 (0xFFFE down to 0xFFF6) → after 8 writes full=1, room_avail=0, data_avail=8; 9th write dropped with count unchanged; full_nxt rises in the cycle of the 8th write.
- Drain and underflow: 10 reads after the fill → read_data sequence 0xFFFE…0xFFF7; empty=1 after the 8th read; reads 9–10 leave read_data=0xFFF7 and count=0.
- Simultaneous read/write at count 3 → count stays 3, flags stable, read_data is the oldest word; at full with both enables high → count becomes 7 and the write is dropped; at empty with both enables high → count becomes 1 and read_data is unchanged.
- Reset mid-operation: 5 words stored, reset for 2 cycles → all state cleared as in the reset scenario; then write/read pairs behave as in the single write/read scenario.
